serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepted start.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.
REQ-009 The block SHALL have port sum, output, WIDTH bits: result, valid from done onward.
REQ-010 The block SHALL have port cout, output, 1 bit: carry-out, valid from done onward.

Function
REQ-011 The block SHALL be a state machine with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL load a, b and cin into internal registers, clear the bit counter, and go to SHIFT.
REQ-013 Each SHIFT cycle SHALL do one full-add of the operand LSBs with the carry register, shift the sum bit into sum from the MSB end, shift both operands right by one, update the carry and increment the counter.
REQ-014 After exactly WIDTH SHIFT cycles the block SHALL go to DONE; cout SHALL equal the final carry.
REQ-015 The block SHALL go from DONE to IDLE unconditionally after one cycle.
REQ-016 Latency: done SHALL be high WIDTH+1 rising edges after the edge that accepted start.
REQ-017 sum and cout SHALL hold their values in IDLE until the next accepted start.
REQ-018 start SHALL be ignored while busy=1; a start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-019 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH of the full sum.
REQ-020 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the carry, counter and operand registers, including mid-operation.
REQ-022 After rst_n is released, the first accepted start SHALL need a rising edge with rst_n high.

Configuration
REQ-023 With SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf, 1 bit: the signed two's-complement overflow (carry into MSB XOR carry out of MSB), registered at the transition into DONE, reset to 0, and held like sum.
REQ-024 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the state typedef (IDLE, SHIFT, DONE) and the default-width constant.
REQ-026 The one-bit sum/carry logic SHALL be a sub-module fa_bit (inputs x, y, ci; outputs s, co), instantiated once.

Verification
REQ-027 WIDTH=8, a=0x5A, b=0x33, cin=0, one-cycle start -> done on the 9th edge; sum=0x8D, cout=0; busy high for 9 cycles.
REQ-028 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; with OVF_EN, ovf=0.
REQ-029 With OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-030 start re-pulsed at cycles 3 and 5 of SHIFT with different operands -> ignored; result matches the first operands.
REQ-031 rst_n asserted at SHIFT cycle 4 -> outputs zero at once, state IDLE; a new start after release gives the correct result.
REQ-032 start held high continuously for three operations -> done pulses every WIDTH+2 cycles; each sum is correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder used as the serial datapath of serial_adder.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per SHIFT cycle, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_bit u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // On the MSB cycle carry_q is the carry into the MSB.
        if (cnt_q == LAST_CNT) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // One complete operation from IDLE; optionally re-pulses start on SHIFT cycles 3 and 5.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        input bit repulse);
    logic [W:0] full;
    bit seen;
    full  = ref_full(oa, ob, oc);
    start = 1'b1;
    a     = oa;
    b     = ob;
    cin   = oc;
    chk("idle_busy", busy, 0);
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    seen  = 0;
    for (int c = 0; c < W + 4 && !seen; c++) begin
      chk("busy_high", busy, 1);
      if (done) begin
        seen = 1;
        chk("latency", c, W);
        chk("sum", sum, full[W-1:0]);
        chk("cout", cout, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, ref_ovf(oa, ob, oc));
`endif
      end else begin
        if (repulse && (c == 2 || c == 4)) begin
          start = 1'b1;
          a     = W'($urandom);
          b     = W'($urandom);
          cin   = 1'($urandom);
        end else begin
          start = 1'b0;
        end
        step();
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    start = 1'b0;
    step();
    chk("after_done_busy", busy, 0);
    chk("after_done_pulse", done, 0);
    a = W'($urandom);
    b = W'($urandom);
    step();
    chk("idle_hold_sum", sum, full[W-1:0]);
    chk("idle_hold_cout", cout, full[W]);
    chk("idle_stays", busy, 0);
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] qa[3], qb[3];
    logic         qc[3];
    int           k, last;

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op(8'h5A, 8'h33, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);

    run_op(8'h3C, 8'h95, 1'b1, 1);

    // Leave a result with cout=1 so the mid-operation reset has something to clear.
    run_op(8'hF0, 8'h20, 1'b0, 0);
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h5D;
    cin   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", ovf, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);
    run_op(8'hC3, 8'h5D, 1'b1, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'(i % 4 == 0));
    end

    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom);
      qb[i] = W'($urandom);
      qc[i] = 1'($urandom);
    end
    a     = qa[0];
    b     = qb[0];
    cin   = qc[0];
    start = 1'b1;
    k     = 0;
    last  = 0;
    for (int cyc = 0; cyc < 3 * (W + 2) + 10 && k < 3; cyc++) begin
      step();
      if (done) begin
        full = ref_full(qa[k], qb[k], qc[k]);
        chk("cont_sum", sum, full[W-1:0]);
        chk("cont_cout", cout, full[W]);
        if (k > 0) chk("cont_interval", cyc - last, W + 2);
        last = cyc;
        k++;
        if (k < 3) begin
          a   = qa[k];
          b   = qb[k];
          cin = qc[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    if (k != 3) chk("cont_timeout", k, 3);
    start = 1'b0;
    step();
    step();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
